// File: rtl/add_serial_seq.sv
// add_serial_seq: operand FIFO, issue sequencer and result collector wrapped
// around the serial adder. One operand pair is in flight at a time; the adder
// is started with an add_en pulse and returned from DONE to IDLE with a second
// pulse once the result has been handed downstream.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | adder idle; pops FIFO head into add_a/add_b when non-empty
// S_ISSUE   | add_en high for one cycle, wait counter loaded
// S_WAIT    | counting down the adder latency, operands held stable
// S_HOLD    | result captured, res_valid high until res_ready
// S_RELEASE | add_en high for one cycle to return the adder to IDLE
module add_serial_seq #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CW-1:0]    r_wait;
    logic             r_add_en;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on the registered count, so a same-cycle pop never
    // opens the input while full.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    assign in_ready  = !w_full;
    assign add_en    = r_add_en;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    // Operand storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count as is.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (!w_empty) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT:    if (r_wait == '0) w_next = S_HOLD;
            S_HOLD:    if (res_ready) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered adder controls, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_add_en    <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_wait      <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
        end else begin
            r_add_en <= (w_next == S_ISSUE) || (w_next == S_RELEASE);
            if (w_pop) begin
                r_add_a <= r_mem_a[r_rd_ptr];
                r_add_b <= r_mem_b[r_rd_ptr];
            end
            if (r_state == S_ISSUE) begin
                r_wait <= WAIT_LOAD;
            end else if ((r_state == S_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - CW'(1);
            end
            if ((r_state == S_WAIT) && (r_wait == '0)) begin
                r_res_sum   <= add_out;
                r_res_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end
endmodule
